// File: rtl/reg_file_wb_pkg.sv
// Shared constants for the MIPS general-purpose register file and its
// write-back decoder.
package reg_file_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Architectural register numbers
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_wb_wb_decoder.sv
// Write-back demultiplexer: turns one destination address plus a write
// strobe into a one-hot register select. Bit 0 never fires, so the zero
// register can never be written.
module wb_decoder
  import reg_file_wb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   en_i,
  input  logic [ADDR_W-1:0]      addr_i,
  output logic [2**ADDR_W-1:0]   onehot_o
);

  // One-hot decode; all-zero when disabled or targeting the zero register
  always_comb begin
    onehot_o = '0;
    if (en_i && (addr_i != ADDR_W'(REG_ZERO))) begin
      onehot_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// 32 x 32 MIPS register file: one write port fed from write-back through a
// one-hot decoder, two combinational read ports for decode with optional
// write-through bypass. Register 0 always reads as zero.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              wr_done
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0]  wr_sel;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              wr_done_q;
  logic              wr_done_d;

  wb_decoder #(
    .ADDR_W   (ADDR_W)
  ) u_wb_decoder (
    .en_i     (wr_en),
    .addr_i   (wr_addr),
    .onehot_o (wr_sel)
  );

  // Any select bit set means a write to a real register was accepted
  assign wr_done_d = |wr_sel;

  // Read-side mux: stored value, overridden by the in-flight write when
  // bypass is enabled; address 0 is forced to zero regardless.
  function automatic logic [DATA_W-1:0] rd_mux(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] res;
    res = stored;
    if ((BYPASS != 0) && we && (waddr == addr)) begin
      res = wdata;
    end
    if (addr == ADDR_W'(REG_ZERO)) begin
      res = '0;
    end
    return res;
  endfunction

  // Register storage and write-done pulse; reset clears everything at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      wr_done_q <= 1'b0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          regs_q[i] <= wr_data;
        end
      end
      wr_done_q <= wr_done_d;
    end
  end

  // Combinational read ports A (rs) and B (rt)
  always_comb begin
    rd_data_a = rd_mux(rd_addr_a, regs_q[rd_addr_a], wr_en, wr_addr, wr_data);
    rd_data_b = rd_mux(rd_addr_b, regs_q[rd_addr_b], wr_en, wr_addr, wr_data);
  end

  assign wr_done = wr_done_q;

endmodule
